// File: rtl/sparse_phase_monitor_if.sv
// Tapped ready/valid stream bundle observed by sparse_phase_monitor.
interface sparse_phase_monitor_if #(
  parameter int unsigned DATA_WIDTH = 17,
  parameter int unsigned NUM_IN     = 2,
  parameter int unsigned NUM_OUT    = 2
);
  logic [NUM_IN*DATA_WIDTH-1:0]  in_data;
  logic [NUM_IN-1:0]             in_valid;
  logic [NUM_IN-1:0]             in_ready;
  logic [NUM_OUT*DATA_WIDTH-1:0] out_data;
  logic [NUM_OUT-1:0]            out_valid;
  logic [NUM_OUT-1:0]            out_ready;

  modport master (output in_data, in_valid, in_ready, out_data, out_valid, out_ready);
  modport slave  (input  in_data, in_valid, in_ready, out_data, out_valid, out_ready);
endinterface

// File: rtl/sparse_phase_monitor.sv
// Passive write/gap/read phase cycle monitor for sparse tile streams.
// Optional per-channel handshake counters enabled by SPARSE_PHASE_MON_XFER_CNT_EN.
module sparse_phase_monitor #(
  parameter int unsigned           DATA_WIDTH = 17,
  parameter int unsigned           NUM_IN     = 2,
  parameter int unsigned           NUM_OUT    = 2,
  parameter int unsigned           CNT_WIDTH  = 32,
  parameter int unsigned           GAP_WIDTH  = 8,
  parameter logic [DATA_WIDTH-1:0] DONE_TOKEN = 17'h10100
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clk_en,
  input  logic                 flush,
  sparse_phase_monitor_if.slave tap,
  input  logic [GAP_WIDTH-1:0] gap_cfg,
  output logic [2:0]           phase,
  output logic [CNT_WIDTH-1:0] write_cycles,
  output logic [CNT_WIDTH-1:0] read_cycles,
  output logic                 done,
  output logic                 saturated
`ifdef SPARSE_PHASE_MON_XFER_CNT_EN
  ,
  output logic [(NUM_IN+NUM_OUT)*CNT_WIDTH-1:0] xfer_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_GAP   = 3'd2,
    S_READ  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [GAP_WIDTH-1:0] GAP_ONE = GAP_WIDTH'(1);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == '1) ? v : v + CNT_ONE;
  endfunction

  state_t               state_q, state_d;
  logic [GAP_WIDTH-1:0] gap_q, gap_d;
  logic [NUM_IN-1:0]    in_done_q, in_done_d;
  logic [NUM_OUT-1:0]   out_done_q, out_done_d;
  logic [CNT_WIDTH-1:0] wcnt_q, wcnt_d;
  logic [CNT_WIDTH-1:0] rcnt_q, rcnt_d;
  logic                 done_q, done_d;
  logic                 sat_q, sat_d;
  logic                 xfer_hit;

  logic [NUM_IN-1:0]    in_fire, in_done_fire;
  logic [NUM_OUT-1:0]   out_fire, out_done_fire;

  always_comb begin
    in_fire       = '0;
    in_done_fire  = '0;
    out_fire      = '0;
    out_done_fire = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      in_fire[i]      = tap.in_valid[i] & tap.in_ready[i];
      in_done_fire[i] = in_fire[i] && (tap.in_data[i*DATA_WIDTH +: DATA_WIDTH] == DONE_TOKEN);
    end
    for (int unsigned j = 0; j < NUM_OUT; j++) begin
      out_fire[j]      = tap.out_valid[j] & tap.out_ready[j];
      out_done_fire[j] = out_fire[j] && (tap.out_data[j*DATA_WIDTH +: DATA_WIDTH] == DONE_TOKEN);
    end
  end

  always_comb begin
    state_d    = state_q;
    gap_d      = gap_q;
    in_done_d  = in_done_q;
    out_done_d = out_done_q;
    wcnt_d     = wcnt_q;
    rcnt_d     = rcnt_q;
    sat_d      = sat_q;
    unique case (state_q)
      S_IDLE: begin
        // The cycle that first sees valid is already part of the write phase.
        if (|tap.in_valid) begin
          state_d   = S_WRITE;
          wcnt_d    = CNT_ONE;
          in_done_d = '0;
        end
      end
      S_WRITE: begin
        wcnt_d    = sat_inc(wcnt_q);
        in_done_d = in_done_q | in_done_fire;
        if (&in_done_d) begin
          gap_d = gap_cfg;
          if (gap_cfg == '0) begin
            state_d    = S_READ;
            out_done_d = '0;
          end else begin
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (gap_q == GAP_ONE) begin
          state_d    = S_READ;
          out_done_d = '0;
        end else begin
          gap_d = gap_q - GAP_ONE;
        end
      end
      S_READ: begin
        rcnt_d     = sat_inc(rcnt_q);
        out_done_d = out_done_q | out_done_fire;
        if (&out_done_d) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    if ((wcnt_d == '1) || (rcnt_d == '1) || xfer_hit) sat_d = 1'b1;

    if (flush) begin
      state_d    = S_IDLE;
      gap_d      = '0;
      in_done_d  = '0;
      out_done_d = '0;
      wcnt_d     = '0;
      rcnt_d     = '0;
      sat_d      = 1'b0;
    end
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      gap_q      <= '0;
      in_done_q  <= '0;
      out_done_q <= '0;
      wcnt_q     <= '0;
      rcnt_q     <= '0;
      done_q     <= 1'b0;
      sat_q      <= 1'b0;
    end else if (clk_en) begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      in_done_q  <= in_done_d;
      out_done_q <= out_done_d;
      wcnt_q     <= wcnt_d;
      rcnt_q     <= rcnt_d;
      done_q     <= done_d;
      sat_q      <= sat_d;
    end
  end

  assign phase        = state_q;
  assign write_cycles = wcnt_q;
  assign read_cycles  = rcnt_q;
  assign done         = done_q;
  assign saturated    = sat_q;

`ifdef SPARSE_PHASE_MON_XFER_CNT_EN
  // Inputs occupy slots 0..NUM_IN-1, outputs follow.
  logic [NUM_IN+NUM_OUT-1:0][CNT_WIDTH-1:0] xfer_q, xfer_d;

  always_comb begin
    xfer_d   = xfer_q;
    xfer_hit = 1'b0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if ((state_q == S_WRITE) && in_fire[i]) xfer_d[i] = sat_inc(xfer_q[i]);
    end
    for (int unsigned j = 0; j < NUM_OUT; j++) begin
      if ((state_q == S_READ) && out_fire[j]) xfer_d[NUM_IN+j] = sat_inc(xfer_q[NUM_IN+j]);
    end
    for (int unsigned k = 0; k < NUM_IN + NUM_OUT; k++) begin
      if (xfer_d[k] == '1) xfer_hit = 1'b1;
    end
    if (flush) begin
      xfer_d   = '0;
      xfer_hit = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_q <= '0;
    end else if (clk_en) begin
      xfer_q <= xfer_d;
    end
  end

  assign xfer_cnt = xfer_q;
`else
  assign xfer_hit = 1'b0;
`endif

endmodule

// File: doc/sparse_phase_monitor.md
# sparse_phase_monitor

Synthesizable, parametrised phase/cycle monitor for sparse tile streams (fiber_access, write scanner, read scanner). It passively taps N input and M output ready/valid streams and measures cycles in each phase: write (inputs streaming until every input channel has transferred its done token), a programmable gap, and read (until every output channel has transferred its done token). It is the on-chip generalisation of the bench-side write/read cycle counter, with arbitrary channel counts, a gap counter, saturating counters and flush handling.

## Interface
Parameters:
- DATA_WIDTH, 17, stream word width including the control bit.
- NUM_IN, 2, number of tapped write-side (input) streams.
- NUM_OUT, 2, number of tapped read-side (output) streams.
- CNT_WIDTH, 32, width of each cycle counter.
- GAP_WIDTH, 8, width of the gap configuration.
- DONE_TOKEN, 17'h10100, done-token encoding (DATA_WIDTH bits).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- clk_en  in  1  clock enable; low freezes all state.
- flush  in  1  synchronous soft reset to IDLE, all counters cleared.
- in_data  in  NUM_IN*DATA_WIDTH  tapped input stream data, channel i at [i*DATA_WIDTH +: DATA_WIDTH].
- in_valid / in_ready  in  NUM_IN  tapped input handshakes.
- out_data  in  NUM_OUT*DATA_WIDTH  tapped output stream data.
- out_valid / out_ready  in  NUM_OUT  tapped output handshakes.
- gap_cfg  in  GAP_WIDTH  gap cycles between write done and read start; sampled on WRITE exit.
- phase  out  3  IDLE=0, WRITE=1, GAP=2, READ=3, DONE=4.
- write_cycles  out  CNT_WIDTH  cycles spent in write phase.
- read_cycles  out  CNT_WIDTH  cycles spent in read phase.
- done  out  1  high in DONE.
- saturated  out  1  sticky: any counter hit all-ones.

## Operation
- Handshake on channel k: valid[k] & ready[k]. Done fire: handshake with data == DONE_TOKEN.
- IDLE: on any in_valid high -> WRITE; write_cycles <= 1 (that cycle counts).
- WRITE: write_cycles increments every enabled cycle. Sticky in_done[i] set on a done fire on input i. When the cycle's done fires complete in_done to all ones, that cycle is still counted; next state GAP with gap_cnt <= gap_cfg, or READ directly if gap_cfg == 0.
- GAP: gap_cnt decrements each cycle; at 1 -> READ. No counters increment.
- READ: read_cycles increments every cycle including the one whose out done fires complete out_done; then -> DONE. Output done fires before READ are ignored (out_done cleared on READ entry).
- DONE: counters hold; leaves only via flush or reset.
- Input done fires outside WRITE are ignored. Multiple done fires on one channel: idempotent.
- Counters saturate at 2^CNT_WIDTH-1 and set saturated; no wrap.
- flush has priority over all transitions; clk_en low holds all state, including the response to flush.

## Timing
- All outputs registered; reset/flush values: phase=IDLE, counters 0, done 0, saturated 0.
- phase updates one cycle after the triggering tap event; counter values visible the cycle after the counted cycle.
- Pure monitor: drives no ready/valid; zero effect on tapped streams.
- Reset asserted mid-phase: immediate return to IDLE, all state cleared.

## Configuration
- SPARSE_PHASE_MON_XFER_CNT_EN: when defined, adds output xfer_cnt (NUM_IN+NUM_OUT)*CNT_WIDTH, per-channel saturating handshake counters (inputs counted in WRITE, outputs in READ, done fire included), cleared by reset/flush. When undefined, the port and counters are absent.

## Test plan
- Basic: NUM_IN=2, NUM_OUT=2, gap_cfg=0; inputs valid at cycle 0, ch0 done fire at cycle 5, ch1 at cycle 9; outputs done at cycles 12 and 20 -> write_cycles=10, read_cycles=11, phase=DONE, done=1.
- Gap: same traffic with gap_cfg=3 -> phase=GAP for exactly 3 cycles; read_cycles still counts from READ entry; early output done fire during GAP is ignored.
- Non-DONE data and unready handshakes: DONE_TOKEN presented with ready=0 for 4 cycles -> in_done not set, WRITE continues until the real fire.
- Saturation: CNT_WIDTH=4, write phase of 20 cycles -> write_cycles=15, saturated=1.
- Flush and reset mid-READ: flush -> next cycle phase=IDLE, counters 0; rst_n low asynchronously clears the same without a clock edge; clk_en=0 during flush -> no change.
- Macro on: 7 input handshakes on ch0, 3 on ch1, 5 on out0 -> xfer_cnt reports 7, 3, 5.
